// File: rtl/dcache_bypass_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_bypass_lsu
//  Purpose  : Registered uncached load/store path for the L1 data side, used
//             when the D-cache is bypassed or absent. Committed stores are
//             lane-positioned and queued in a small FIFO. Loads run through a
//             small FSM that orders them behind older stores, issues one beat
//             request, then aligns and extends the returned bytes.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W   : data path width, 32 or 64
//    ADDR_W   : byte address width
//    ST_DEPTH : store FIFO entries, power of two in 2..16
//    BE_W     : byte-enable width, derived from DATA_W
//  Ports
//    clk, reset (async, active low), recoverFlag_i (pipeline flush)
//    ld*_i/o    : load request / accept / registered response
//    st*_i/o    : committed store push / ready / illegal-store pulse
//    memLd*     : beat load request, grant and response
//    memSt*     : FIFO head presented to memory, popped on grant
//    stBufEmpty_o, stBufCount_o : FIFO status
//  Optional feature
//    DCACHE_BYPASS_STFWD_EN : when defined, a load whose bytes are all covered
//    by the youngest matching queued store is answered from the FIFO through
//    state FWD. A load with no match goes to memory without draining.
// ============================================================================
module dcache_bypass_lsu #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 64,
    parameter int ST_DEPTH = 4,
    parameter int BE_W     = DATA_W / 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        recoverFlag_i,
    // load port
    input  logic                        ldReq_i,
    output logic                        ldReady_o,
    input  logic [ADDR_W-1:0]           ldAddr_i,
    input  logic [1:0]                  ldSize_i,
    input  logic                        ldSign_i,
    output logic                        ldRespValid_o,
    output logic [DATA_W-1:0]           ldData_o,
    output logic                        ldMisalign_o,
    // store port
    input  logic                        stReq_i,
    output logic                        stReady_o,
    input  logic [ADDR_W-1:0]           stAddr_i,
    input  logic [1:0]                  stSize_i,
    input  logic [DATA_W-1:0]           stData_i,
    output logic                        stMisalign_o,
    // memory load channel
    output logic                        memLdReq_o,
    output logic [ADDR_W-1:0]           memLdAddr_o,
    input  logic                        memLdGnt_i,
    input  logic                        memLdRespValid_i,
    input  logic [DATA_W-1:0]           memLdData_i,
    // memory store channel
    output logic                        memStReq_o,
    output logic [ADDR_W-1:0]           memStAddr_o,
    output logic [DATA_W-1:0]           memStData_o,
    output logic [BE_W-1:0]             memStByteEn_o,
    input  logic                        memStGnt_i,
    // status
    output logic                        stBufEmpty_o,
    output logic [$clog2(ST_DEPTH):0]   stBufCount_o
);

    localparam int OFF_W = $clog2(BE_W);
    localparam int PTR_W = $clog2(ST_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    // Illegal when the size exceeds the beat or the address is not
    // naturally aligned to the access size.
    function automatic logic f_illegal(input logic [1:0] size,
                                       input logic [OFF_W-1:0] off);
        logic bad;
        bad = ({1'b0, size} > 3'(OFF_W));
        for (int k = 0; k < OFF_W; k++) begin
            if ((k < int'(size)) && off[k]) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [BE_W-1:0] f_low_be(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m[BE_W-1:0];
    endfunction

    // Pull the accessed bytes down to bit 0 and zero/sign extend.
    function automatic logic [DATA_W-1:0] f_extract(input logic [DATA_W-1:0] beat,
                                                    input logic [OFF_W-1:0]  off,
                                                    input logic [1:0]        size,
                                                    input logic              sign);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] res;
        logic              msb;
        int                nb;
        sh  = beat >> {off, 3'b000};
        nb  = 8 << size;
        if (nb > DATA_W) nb = DATA_W;
        msb = sign & sh[nb-1];
        for (int i = 0; i < DATA_W; i++) begin
            res[i] = (i < nb) ? sh[i] : msb;
        end
        return res;
    endfunction

    function automatic logic [ADDR_W-1:0] f_beat(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    // ------------------------------------------------------------------
    // Store FIFO
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] fifo_addr_q [ST_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [ST_DEPTH];
    logic [BE_W-1:0]   fifo_be_q   [ST_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              st_misalign_q;

    logic              w_fifo_empty;
    logic              w_st_illegal;
    logic              w_st_push;
    logic              w_st_pop;
    logic [OFF_W-1:0]  w_st_off;

    assign w_fifo_empty = (count_q == '0);
    assign stReady_o    = (count_q != CNT_W'(ST_DEPTH));
    assign w_st_off     = stAddr_i[OFF_W-1:0];
    assign w_st_illegal = f_illegal(stSize_i, w_st_off);
    assign w_st_push    = stReq_i & stReady_o & ~w_st_illegal;
    assign w_st_pop     = memStGnt_i & ~w_fifo_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_st_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_st_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({w_st_push, w_st_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            st_misalign_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            st_misalign_q <= stReq_i & stReady_o & w_st_illegal;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_st_push) begin
            fifo_addr_q[wr_ptr_q] <= f_beat(stAddr_i);
            fifo_data_q[wr_ptr_q] <= stData_i << {w_st_off, 3'b000};
            fifo_be_q[wr_ptr_q]   <= f_low_be(stSize_i) << w_st_off;
        end
    end

    assign memStReq_o    = ~w_fifo_empty;
    assign memStAddr_o   = w_fifo_empty ? '0 : fifo_addr_q[rd_ptr_q];
    assign memStData_o   = w_fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
    assign memStByteEn_o = w_fifo_empty ? '0 : fifo_be_q[rd_ptr_q];
    assign stMisalign_o  = st_misalign_q;
    assign stBufEmpty_o  = w_fifo_empty;
    assign stBufCount_o  = count_q;

    // ------------------------------------------------------------------
    // Load FSM
    // ------------------------------------------------------------------
`ifdef DCACHE_BYPASS_STFWD_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAIN = 3'd1,
        S_REQ   = 3'd2,
        S_RESP  = 3'd3,
        S_DROP  = 3'd4,
        S_ERR   = 3'd5,
        S_FWD   = 3'd6
    } ld_state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAIN = 3'd1,
        S_REQ   = 3'd2,
        S_RESP  = 3'd3,
        S_DROP  = 3'd4,
        S_ERR   = 3'd5
    } ld_state_t;
`endif

    ld_state_t         state_q, state_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [1:0]        ld_size_q, ld_size_d;
    logic              ld_sign_q, ld_sign_d;
    logic              ld_resp_valid_q, ld_resp_valid_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;
    logic              ld_misalign_q, ld_misalign_d;
    logic              mem_ld_req;

    logic              w_ld_accept;
    logic              w_ld_illegal;
    logic [OFF_W-1:0]  w_ld_off_q;

    assign ldReady_o    = (state_q == S_IDLE);
    // A flush in IDLE refuses the load offered that cycle.
    assign w_ld_accept  = ldReq_i & ldReady_o & ~recoverFlag_i;
    assign w_ld_illegal = f_illegal(ldSize_i, ldAddr_i[OFF_W-1:0]);
    assign w_ld_off_q   = ld_addr_q[OFF_W-1:0];

`ifdef DCACHE_BYPASS_STFWD_EN
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic              w_hit;
    logic              w_hit_cover;
    logic [BE_W-1:0]   w_hit_be;
    logic [DATA_W-1:0] w_hit_data;
    logic [BE_W-1:0]   w_ld_be;
    logic              w_push_hit;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        w_hit      = 1'b0;
        w_hit_be   = '0;
        w_hit_data = '0;
        idx        = '0;
        for (int i = 0; i < ST_DEPTH; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (fifo_addr_q[idx] == f_beat(ldAddr_i))) begin
                w_hit      = 1'b1;
                w_hit_be   = fifo_be_q[idx];
                w_hit_data = fifo_data_q[idx];
            end
        end
    end

    assign w_ld_be     = f_low_be(ldSize_i) << ldAddr_i[OFF_W-1:0];
    assign w_hit_cover = w_hit && ((w_hit_be & w_ld_be) == w_ld_be);
    // A store entering this very cycle is younger than anything queued;
    // if it touches the same beat the FIFO contents are not authoritative.
    assign w_push_hit  = w_st_push && (f_beat(stAddr_i) == f_beat(ldAddr_i));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fwd_data_q <= '0;
        else        fwd_data_q <= fwd_data_d;
    end
`endif

    always_comb begin
        state_d         = state_q;
        ld_addr_d       = ld_addr_q;
        ld_size_d       = ld_size_q;
        ld_sign_d       = ld_sign_q;
        ld_resp_valid_d = 1'b0;
        ld_misalign_d   = 1'b0;
        ld_data_d       = ld_data_q;
        mem_ld_req      = 1'b0;
`ifdef DCACHE_BYPASS_STFWD_EN
        fwd_data_d      = fwd_data_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_ld_accept) begin
                    ld_addr_d = ldAddr_i;
                    ld_size_d = ldSize_i;
                    ld_sign_d = ldSign_i;
                    if (w_ld_illegal) begin
                        state_d = S_ERR;
`ifdef DCACHE_BYPASS_STFWD_EN
                    end else if (w_push_hit || (w_hit && !w_hit_cover)) begin
                        state_d = S_DRAIN;
                    end else if (w_hit_cover) begin
                        state_d    = S_FWD;
                        fwd_data_d = w_hit_data;
`else
                    end else if (!w_fifo_empty || w_st_push) begin
                        state_d = S_DRAIN;
`endif
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_DRAIN: begin
                if (recoverFlag_i)     state_d = S_IDLE;
                else if (w_fifo_empty) state_d = S_REQ;
            end
            S_REQ: begin
                // A flush without grant withdraws the request at once; with
                // a grant the beat is already owed and must be swallowed.
                mem_ld_req = ~(recoverFlag_i & ~memLdGnt_i);
                if (recoverFlag_i) state_d = memLdGnt_i ? S_DROP : S_IDLE;
                else if (memLdGnt_i) state_d = S_RESP;
            end
            S_RESP: begin
                if (memLdRespValid_i) begin
                    state_d = S_IDLE;
                    if (!recoverFlag_i) begin
                        ld_resp_valid_d = 1'b1;
                        ld_data_d = f_extract(memLdData_i, w_ld_off_q, ld_size_q, ld_sign_q);
                    end
                end else if (recoverFlag_i) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (memLdRespValid_i) state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
                if (!recoverFlag_i) begin
                    ld_resp_valid_d = 1'b1;
                    ld_misalign_d   = 1'b1;
                    ld_data_d       = '0;
                end
            end
`ifdef DCACHE_BYPASS_STFWD_EN
            S_FWD: begin
                state_d = S_IDLE;
                if (!recoverFlag_i) begin
                    ld_resp_valid_d = 1'b1;
                    ld_data_d = f_extract(fwd_data_q, w_ld_off_q, ld_size_q, ld_sign_q);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            ld_addr_q       <= '0;
            ld_size_q       <= '0;
            ld_sign_q       <= 1'b0;
            ld_resp_valid_q <= 1'b0;
            ld_data_q       <= '0;
            ld_misalign_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            ld_addr_q       <= ld_addr_d;
            ld_size_q       <= ld_size_d;
            ld_sign_q       <= ld_sign_d;
            ld_resp_valid_q <= ld_resp_valid_d;
            ld_data_q       <= ld_data_d;
            ld_misalign_q   <= ld_misalign_d;
        end
    end

    assign memLdReq_o    = mem_ld_req;
    assign memLdAddr_o   = f_beat(ld_addr_q);
    assign ldRespValid_o = ld_resp_valid_q;
    assign ldData_o      = ld_data_q;
    assign ldMisalign_o  = ld_misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_bypass_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_bypass_lsu
//  Purpose  : Directed self-checking bench for dcache_bypass_lsu: a 64-bit
//             instance for load/store/FIFO/flush scenarios and a 32-bit
//             instance for the oversize-load error path.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dcache_bypass_lsu;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- 64-bit instance ----------------
    logic        recover;
    logic        ldReq, ldReady, ldSign, ldRespValid, ldMisalign;
    logic [63:0] ldAddr, ldData;
    logic [1:0]  ldSize;
    logic        stReq, stReady, stMisalign;
    logic [63:0] stAddr, stData;
    logic [1:0]  stSize;
    logic        memLdReq, memLdGnt, memLdRespValid;
    logic [63:0] memLdAddr, memLdData;
    logic        memStReq, memStGnt;
    logic [63:0] memStAddr, memStData;
    logic [7:0]  memStByteEn;
    logic        stBufEmpty;
    logic [2:0]  stBufCount;

    dcache_bypass_lsu #(.DATA_W(64), .ADDR_W(64), .ST_DEPTH(4)) u_dut64 (
        .clk(clk), .reset(reset), .recoverFlag_i(recover),
        .ldReq_i(ldReq), .ldReady_o(ldReady), .ldAddr_i(ldAddr), .ldSize_i(ldSize),
        .ldSign_i(ldSign), .ldRespValid_o(ldRespValid), .ldData_o(ldData),
        .ldMisalign_o(ldMisalign),
        .stReq_i(stReq), .stReady_o(stReady), .stAddr_i(stAddr), .stSize_i(stSize),
        .stData_i(stData), .stMisalign_o(stMisalign),
        .memLdReq_o(memLdReq), .memLdAddr_o(memLdAddr), .memLdGnt_i(memLdGnt),
        .memLdRespValid_i(memLdRespValid), .memLdData_i(memLdData),
        .memStReq_o(memStReq), .memStAddr_o(memStAddr), .memStData_o(memStData),
        .memStByteEn_o(memStByteEn), .memStGnt_i(memStGnt),
        .stBufEmpty_o(stBufEmpty), .stBufCount_o(stBufCount)
    );

    // ---------------- 32-bit instance ----------------
    logic        ldReq2, ldReady2, ldRespValid2, ldMisalign2;
    logic [31:0] ldAddr2, ldData2;
    logic [1:0]  ldSize2;
    logic        stReady2, stMisalign2, memLdReq2, memStReq2, stBufEmpty2;
    logic [31:0] memLdAddr2, memStAddr2, memStData2;
    logic [3:0]  memStByteEn2;
    logic [2:0]  stBufCount2;

    dcache_bypass_lsu #(.DATA_W(32), .ADDR_W(32), .ST_DEPTH(4)) u_dut32 (
        .clk(clk), .reset(reset), .recoverFlag_i(1'b0),
        .ldReq_i(ldReq2), .ldReady_o(ldReady2), .ldAddr_i(ldAddr2), .ldSize_i(ldSize2),
        .ldSign_i(1'b0), .ldRespValid_o(ldRespValid2), .ldData_o(ldData2),
        .ldMisalign_o(ldMisalign2),
        .stReq_i(1'b0), .stReady_o(stReady2), .stAddr_i(32'h0), .stSize_i(2'd0),
        .stData_i(32'h0), .stMisalign_o(stMisalign2),
        .memLdReq_o(memLdReq2), .memLdAddr_o(memLdAddr2), .memLdGnt_i(1'b0),
        .memLdRespValid_i(1'b0), .memLdData_i(32'h0),
        .memStReq_o(memStReq2), .memStAddr_o(memStAddr2), .memStData_o(memStData2),
        .memStByteEn_o(memStByteEn2), .memStGnt_i(1'b0),
        .stBufEmpty_o(stBufEmpty2), .stBufCount_o(stBufCount2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one load through accept, immediate grant and next-cycle
    // response; returns what the DUT shows three cycles after accept.
    task automatic issue_load(input logic [63:0] addr, input logic [1:0] size,
                              input logic sign, input logic [63:0] beat,
                              output logic v, output logic [63:0] d);
        ldReq = 1'b1; ldAddr = addr; ldSize = size; ldSign = sign;
        step();
        ldReq = 1'b0;
        memLdGnt = 1'b1;
        step();
        memLdGnt = 1'b0; memLdRespValid = 1'b1; memLdData = beat;
        step();
        memLdRespValid = 1'b0;
        v = ldRespValid;
        d = ldData;
    endtask

    task automatic test_reset();
        reset = 1'b0; recover = 1'b0;
        ldReq = 0; ldAddr = 0; ldSize = 0; ldSign = 0;
        stReq = 0; stAddr = 0; stSize = 0; stData = 0;
        memLdGnt = 0; memLdRespValid = 0; memLdData = 0; memStGnt = 0;
        ldReq2 = 0; ldAddr2 = 0; ldSize2 = 0;
        repeat (3) step();
        reset = 1'b1;
        step();
        n_checks++;
        if ({ldReady, stReady, stBufEmpty} !== 3'b111) begin
            n_fail++; $display("FAIL reset_ready got=%b exp=111", {ldReady, stReady, stBufEmpty});
        end
        n_checks++;
        if ({memLdReq, memStReq, ldRespValid, ldMisalign, stMisalign, stBufCount, memStByteEn} !== 16'h0) begin
            n_fail++; $display("FAIL reset_zero got=%h exp=0",
                {memLdReq, memStReq, ldRespValid, ldMisalign, stMisalign, stBufCount, memStByteEn});
        end
        n_checks++;
        if ({ldReady2, stBufEmpty2, memLdReq2} !== 3'b110) begin
            n_fail++; $display("FAIL reset_dut32 got=%b exp=110", {ldReady2, stBufEmpty2, memLdReq2});
        end
    endtask

    task automatic test_load_sign();
        logic        v;
        logic [63:0] d;
        ldReq = 1'b1; ldAddr = 64'h1003; ldSize = 2'd0; ldSign = 1'b1;
        n_checks++;
        if (ldReady !== 1'b1) begin n_fail++; $display("FAIL lb_ready got=%b exp=1", ldReady); end
        step();
        ldReq = 1'b0;
        n_checks++;
        if (memLdReq !== 1'b1 || memLdAddr !== 64'h1000) begin
            n_fail++; $display("FAIL lb_memreq got=%b/%h exp=1/1000", memLdReq, memLdAddr);
        end
        memLdGnt = 1'b1;
        step();
        memLdGnt = 1'b0; memLdRespValid = 1'b1; memLdData = 64'h0000_0000_8000_0000;
        n_checks++;
        if (ldRespValid !== 1'b0) begin n_fail++; $display("FAIL lb_early got=%b exp=0", ldRespValid); end
        step();
        memLdRespValid = 1'b0;
        n_checks++;
        if (ldRespValid !== 1'b1 || ldData !== 64'hFFFF_FFFF_FFFF_FF80) begin
            n_fail++; $display("FAIL lb_sext got=%b/%h exp=1/ffffffffffffff80", ldRespValid, ldData);
        end
        step();
        n_checks++;
        if (ldRespValid !== 1'b0) begin n_fail++; $display("FAIL lb_pulse got=%b exp=0", ldRespValid); end
        issue_load(64'h1003, 2'd0, 1'b1, 64'h0000_0000_7F00_0000, v, d);
        n_checks++;
        if (v !== 1'b1 || d !== 64'h7F) begin
            n_fail++; $display("FAIL lb_pos got=%b/%h exp=1/7f", v, d);
        end
        step();
    endtask

    task automatic test_store();
        stReq = 1'b1; stAddr = 64'h2006; stSize = 2'd1; stData = 64'hBEEF;
        step();
        stReq = 1'b0;
        n_checks++;
        if (memStReq !== 1'b1 || memStByteEn !== 8'hC0 || memStAddr !== 64'h2000 ||
            memStData !== 64'hBEEF_0000_0000_0000 || stBufCount !== 3'd1) begin
            n_fail++; $display("FAIL sh_lane got=%b/%h/%h/%h/%0d exp=1/c0/2000/beef000000000000/1",
                memStReq, memStByteEn, memStAddr, memStData, stBufCount);
        end
        memStGnt = 1'b1;
        step();
        memStGnt = 1'b0;
        n_checks++;
        if (stBufEmpty !== 1'b1) begin n_fail++; $display("FAIL sh_pop got=%b exp=1", stBufEmpty); end
        stReq = 1'b1; stAddr = 64'h2005; stSize = 2'd1;
        step();
        stReq = 1'b0;
        n_checks++;
        if (stMisalign !== 1'b1 || stBufCount !== 3'd0) begin
            n_fail++; $display("FAIL sh_misalign got=%b/%0d exp=1/0", stMisalign, stBufCount);
        end
        step();
        n_checks++;
        if (stMisalign !== 1'b0) begin n_fail++; $display("FAIL sh_misalign_pulse got=%b exp=0", stMisalign); end
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 4; i++) begin
            stReq = 1'b1; stAddr = 64'h4000 + 64'(8 * i); stSize = 2'd3; stData = 64'(i + 1);
            step();
        end
        n_checks++;
        if (stReady !== 1'b0 || stBufCount !== 3'd4) begin
            n_fail++; $display("FAIL full got=%b/%0d exp=0/4", stReady, stBufCount);
        end
        memStGnt = 1'b1;   // 5th push still offered alongside a pop
        step();
        stReq = 1'b0;
        n_checks++;
        if (stBufCount !== 3'd3 || stReady !== 1'b1 || memStAddr !== 64'h4008) begin
            n_fail++; $display("FAIL full_push_pop got=%0d/%b/%h exp=3/1/4008", stBufCount, stReady, memStAddr);
        end
        repeat (3) step();
        memStGnt = 1'b0;
        n_checks++;
        if (stBufEmpty !== 1'b1 || stBufCount !== 3'd0) begin
            n_fail++; $display("FAIL full_drain got=%b/%0d exp=1/0", stBufEmpty, stBufCount);
        end
    endtask

    task automatic test_drain();
        bit seen;
        for (int i = 0; i < 2; i++) begin
            stReq = 1'b1; stAddr = 64'h5000 + 64'(8 * i); stSize = 2'd3; stData = 64'hA;
            step();
        end
        stReq = 1'b0;
        ldReq = 1'b1; ldAddr = 64'h3000; ldSize = 2'd3; ldSign = 1'b0;
        step();
        ldReq = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (memLdReq !== 1'b0) begin n_fail++; $display("FAIL drain_hold[%0d] got=%b exp=0", i, memLdReq); end
            step();
        end
        memStGnt = 1'b1;
        step();
        step();
        memStGnt = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (memLdReq === 1'b1) seen = 1'b1;
            else step();
        end
        n_checks++;
        if (!seen || stBufEmpty !== 1'b1) begin
            n_fail++; $display("FAIL drain_req got=%b/%b exp=1/1", seen, stBufEmpty);
        end
        memLdGnt = 1'b1;
        step();
        memLdGnt = 1'b0; memLdRespValid = 1'b1; memLdData = 64'h1122_3344_5566_7788;
        step();
        memLdRespValid = 1'b0;
        n_checks++;
        if (ldRespValid !== 1'b1 || ldData !== 64'h1122_3344_5566_7788) begin
            n_fail++; $display("FAIL drain_data got=%b/%h exp=1/1122334455667788", ldRespValid, ldData);
        end
        step();
    endtask

    task automatic test_recover();
        logic        v;
        logic [63:0] d;
        int          bad;
        ldReq = 1'b1; ldAddr = 64'h1000; ldSize = 2'd2; ldSign = 1'b0;
        step();
        ldReq = 1'b0; memLdGnt = 1'b1;
        step();
        memLdGnt = 1'b0; recover = 1'b1;
        step();
        recover = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (ldRespValid !== 1'b0 || ldReady !== 1'b0) bad++;
            step();
        end
        memLdRespValid = 1'b1; memLdData = 64'hDEAD_BEEF_DEAD_BEEF;
        step();
        memLdRespValid = 1'b0;
        if (ldRespValid !== 1'b0) bad++;
        step();
        n_checks++;
        if (bad != 0 || ldRespValid !== 1'b0) begin
            n_fail++; $display("FAIL recover_drop got=%0d strobes/busy exp=0", bad);
        end
        n_checks++;
        if (ldReady !== 1'b1) begin n_fail++; $display("FAIL recover_idle got=%b exp=1", ldReady); end
        issue_load(64'h1004, 2'd2, 1'b0, 64'hCAFE_BABE_1234_5678, v, d);
        n_checks++;
        if (v !== 1'b1 || d !== 64'h0000_0000_CAFE_BABE) begin
            n_fail++; $display("FAIL recover_next got=%b/%h exp=1/cafebabe", v, d);
        end
        step();
    endtask

    task automatic test_dw32_oversize();
        ldReq2 = 1'b1; ldAddr2 = 32'h0; ldSize2 = 2'd3;
        step();
        ldReq2 = 1'b0;
        n_checks++;
        if (memLdReq2 !== 1'b0 || ldRespValid2 !== 1'b0) begin
            n_fail++; $display("FAIL dw32_err_early got=%b/%b exp=0/0", memLdReq2, ldRespValid2);
        end
        step();
        n_checks++;
        if (ldRespValid2 !== 1'b1 || ldMisalign2 !== 1'b1 || ldData2 !== 32'h0 || memLdReq2 !== 1'b0) begin
            n_fail++; $display("FAIL dw32_err got=%b/%b/%h/%b exp=1/1/0/0",
                ldRespValid2, ldMisalign2, ldData2, memLdReq2);
        end
        step();
        n_checks++;
        if (ldRespValid2 !== 1'b0 || ldReady2 !== 1'b1) begin
            n_fail++; $display("FAIL dw32_err_pulse got=%b/%b exp=0/1", ldRespValid2, ldReady2);
        end
    endtask

    initial begin
        test_reset();
        test_load_sign();
        test_store();
        test_fifo_full();
        test_drain();
        test_recover();
        test_dw32_oversize();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
